// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the memory-mapped UART transmitter (uart_tx_dev) and
// its TX FIFO (uart_fifo).
//   - Register offsets as seen on Addr[3:2]
//   - CTRL / STATUS bit positions
//   - Transmitter FSM state encoding
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

    // Register select values (Addr[3:2]); byte offset = value * 4
    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_DIVISOR = 2'd1;
    localparam logic [1:0] REG_DATA    = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    // CTRL bit positions
    localparam int CTRL_EN_BIT      = 0;
    localparam int CTRL_IRQ_EN_BIT  = 1;
    localparam int CTRL_PAR_ODD_BIT = 2;

    // STATUS bit positions
    localparam int STAT_FULL_BIT  = 0;
    localparam int STAT_EMPTY_BIT = 1;
    localparam int STAT_BUSY_BIT  = 2;
    localparam int STAT_OVF_BIT   = 3;
    localparam int STAT_CNT_LSB   = 4;

    // Transmitter states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// -----------------------------------------------------------------------------
// uart_fifo
// Synchronous byte FIFO buffering bytes waiting to be transmitted.
// Head entry is presented combinationally on o_dout (show-ahead), so a pop
// consumes the byte already visible.
// Ports:
//   clk      in   system clock
//   reset    in   synchronous active-high reset; flushes the FIFO
//   i_push   in   write i_din (ignored while full)
//   i_pop    in   discard head entry (ignored while empty)
//   i_din    in   [7:0] byte to store
//   o_dout   out  [7:0] head entry
//   o_full   out  count == FIFO_DEPTH
//   o_empty  out  count == 0
//   o_count  out  number of stored entries
// FIFO_DEPTH must be a power of 2, at least 2 (pointers wrap naturally).
// -----------------------------------------------------------------------------
module uart_fifo #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_push,
    input  logic                          i_pop,
    input  logic [7:0]                    i_din,
    output logic [7:0]                    o_dout,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [$clog2(FIFO_DEPTH):0]   o_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_push_ok;
    logic w_pop_ok;

    // Full/empty are judged on the pre-edge count, so a push into a full
    // FIFO is dropped even if a pop happens in the same cycle.
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by the pointers/count.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == CW'(FIFO_DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/uart_tx_dev.sv
// -----------------------------------------------------------------------------
// uart_tx_dev
// Memory-mapped UART transmitter. Bytes written to DATA are queued in a small
// FIFO and sent as 8N1 frames on txd, LSB first, each bit lasting DIVISOR+1
// clocks. A level interrupt reports that the transmitter has drained.
//
// Register map (Addr[3:2]):
//   0x0 CTRL    RW  bit0 EN, bit1 IRQ_EN, bit2 PAR_ODD (parity builds only)
//   0x4 DIVISOR RW  bits[15:0]
//   0x8 DATA    WO  write pushes Din[7:0]; reads 0
//   0xC STATUS  RO  bit0 FULL, bit1 EMPTY, bit2 BUSY, bit3 OVF (write 1 clears),
//                   bits[6:4] FIFO count saturated at 7
//
// Ports:
//   clk    in   system clock
//   reset  in   synchronous active-high reset
//   Addr   in   [31:0] bus address, only [3:2] decoded
//   WE     in   write strobe (already gated by the bridge)
//   Din    in   [31:0] write data
//   Dout   out  [31:0] read data, combinational from Addr[3:2]
//   IRQ    out  IRQ_EN & EMPTY & idle
//   txd    out  serial output, idle high
//
// Build option: define UART_TX_PARITY_EN to add CTRL.PAR_ODD and a parity bit
// between the data bits and the stop bit (11-bit frame).
// -----------------------------------------------------------------------------
module uart_tx_dev
    import uart_pkg::*;
#(
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ,
    output logic        txd
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // Register file
    logic        r_en;
    logic        r_irq_en;
    logic [15:0] r_divisor;
    logic        r_ovf;
`ifdef UART_TX_PARITY_EN
    logic        r_par_odd;
    logic        r_par_bit;
`endif

    // Transmitter
    tx_state_t   r_state;
    tx_state_t   w_state_next;
    logic [15:0] r_period;
    logic [15:0] r_baud;
    logic [2:0]  r_bitcnt;
    logic [7:0]  r_shift;
    logic        w_pop;
    logic        w_bit_end;
    logic        w_txd;

    // Bus decode
    logic [1:0]  w_sel;
    logic        w_wr_ctrl;
    logic        w_wr_div;
    logic        w_wr_data;
    logic        w_wr_stat;

    // FIFO
    logic [7:0]    w_fifo_dout;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_fifo_count;

    // Address/data bits that the register map never looks at
    logic w_unused;
    assign w_unused = ^{Addr[31:4], Addr[1:0], Din[31:16]};

    function automatic logic [2:0] sat_count3(input logic [31:0] c);
        if (c > 32'd7) begin
            return 3'd7;
        end
        return c[2:0];
    endfunction

    assign w_sel     = Addr[3:2];
    assign w_wr_ctrl = WE && (w_sel == REG_CTRL);
    assign w_wr_div  = WE && (w_sel == REG_DIVISOR);
    assign w_wr_data = WE && (w_sel == REG_DATA);
    assign w_wr_stat = WE && (w_sel == REG_STATUS);

    uart_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_wr_data),
        .i_pop   (w_pop),
        .i_din   (Din[7:0]),
        .o_dout  (w_fifo_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_fifo_count)
    );

    // Register writes
    always_ff @(posedge clk) begin
        if (reset) begin
            r_en      <= 1'b0;
            r_irq_en  <= 1'b0;
            r_divisor <= DEFAULT_DIV;
            r_ovf     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_par_odd <= 1'b0;
`endif
        end else begin
            if (w_wr_ctrl) begin
                r_en     <= Din[CTRL_EN_BIT];
                r_irq_en <= Din[CTRL_IRQ_EN_BIT];
`ifdef UART_TX_PARITY_EN
                r_par_odd <= Din[CTRL_PAR_ODD_BIT];
`endif
            end
            if (w_wr_div) begin
                r_divisor <= Din[15:0];
            end
            // A DATA write and a STATUS write cannot coincide (different
            // offsets), so set and clear never compete.
            if (w_wr_data && w_full) begin
                r_ovf <= 1'b1;
            end else if (w_wr_stat && Din[STAT_OVF_BIT]) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    assign w_bit_end = (r_baud == r_period);

    // FSM next-state and txd decode
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_txd        = 1'b1;
        case (r_state)
            ST_IDLE: begin
                if (r_en && !w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                w_txd = 1'b0;
                if (w_bit_end) begin
                    w_state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                w_txd = r_shift[0];
                if (w_bit_end && (r_bitcnt == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
                    w_state_next = ST_PARITY;
`else
                    w_state_next = ST_STOP;
`endif
                end
            end
            ST_PARITY: begin
`ifdef UART_TX_PARITY_EN
                w_txd = r_par_bit;
`endif
                if (w_bit_end) begin
                    w_state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_bit_end) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Bit timing. The period is captured at the pop so a DIVISOR write only
    // affects the next frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_baud   <= '0;
            r_bitcnt <= '0;
            r_period <= DEFAULT_DIV;
        end else if (w_pop) begin
            r_baud   <= '0;
            r_bitcnt <= '0;
            r_period <= r_divisor;
        end else if (r_state != ST_IDLE) begin
            if (w_bit_end) begin
                r_baud <= '0;
                if (r_state == ST_DATA) begin
                    r_bitcnt <= r_bitcnt + 3'd1;
                end
            end else begin
                r_baud <= r_baud + 16'd1;
            end
        end
    end

    // Frame payload; only meaningful while a frame is in flight
    always_ff @(posedge clk) begin
        if (w_pop) begin
            r_shift <= w_fifo_dout;
`ifdef UART_TX_PARITY_EN
            r_par_bit <= (^w_fifo_dout) ^ r_par_odd;
`endif
        end else if ((r_state == ST_DATA) && w_bit_end) begin
            r_shift <= {1'b0, r_shift[7:1]};
        end
    end

    // Read mux
    always_comb begin
        Dout = '0;
        case (w_sel)
            REG_CTRL: begin
                Dout[CTRL_EN_BIT]     = r_en;
                Dout[CTRL_IRQ_EN_BIT] = r_irq_en;
`ifdef UART_TX_PARITY_EN
                Dout[CTRL_PAR_ODD_BIT] = r_par_odd;
`else
                Dout[CTRL_PAR_ODD_BIT] = 1'b0;
`endif
            end
            REG_DIVISOR: begin
                Dout[15:0] = r_divisor;
            end
            REG_DATA: begin
                Dout = '0;
            end
            REG_STATUS: begin
                Dout[STAT_FULL_BIT]             = w_full;
                Dout[STAT_EMPTY_BIT]            = w_empty;
                Dout[STAT_BUSY_BIT]             = (r_state != ST_IDLE);
                Dout[STAT_OVF_BIT]              = r_ovf;
                Dout[STAT_CNT_LSB +: 3]         = sat_count3(32'(w_fifo_count));
            end
            default: begin
                Dout = '0;
            end
        endcase
    end

    assign IRQ = r_irq_en && w_empty && (r_state == ST_IDLE);
    assign txd = w_txd;

endmodule

// File: tb/tb_uart_tx_dev.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_dev
// Directed bench for uart_tx_dev: register reset values, frame shape and
// timing, FIFO overflow, IRQ behaviour, mid-frame DIVISOR change and
// mid-frame reset. Parity cases are compiled in with UART_TX_PARITY_EN.
// -----------------------------------------------------------------------------
module tb_uart_tx_dev;

    localparam logic [31:0] A_CTRL = 32'h0;
    localparam logic [31:0] A_DIV  = 32'h4;
    localparam logic [31:0] A_DATA = 32'h8;
    localparam logic [31:0] A_STAT = 32'hC;

    logic        clk;
    logic        reset;
    logic [31:0] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;
    logic        txd;

    int n_vec;
    int n_bad;

    uart_tx_dev #(
        .FIFO_DEPTH  (4),
        .DEFAULT_DIV (16'd9)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (Addr),
        .WE    (WE),
        .Din   (Din),
        .Dout  (Dout),
        .IRQ   (IRQ),
        .txd   (txd)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one cycle; bus idles on STATUS so BUSY can be sampled.
    task automatic step();
        @(negedge clk);
        WE   = 1'b0;
        Addr = A_STAT;
        #1;
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        Addr = a;
        Din  = d;
        WE   = 1'b1;
        step();
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        @(negedge clk);
        Addr = a;
        #1;
        chk(tag, Dout, exp);
    endtask

    // Called in the first start-bit cycle. Checks every bit period of the
    // frame, then the idle cycle that follows it. mid_div >= 0 writes
    // DIVISOR during data bit 2.
    task automatic expect_frame(input logic [7:0] b, input int div, input logic irq_after,
                                input int mid_div, input logic par);
        logic [11:0] bits;
        logic [15:0] s_txd;
        logic [15:0] s_busy;
        logic [15:0] s_irq;
        logic [15:0] ones;
        int          n;
        bits = '0;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
        bits[9]  = par;
        bits[10] = 1'b1;
        n = 11;
`else
        bits[9] = 1'b1;
        n = 10;
        if (par) bits[11] = 1'b0;
`endif
        ones = 16'((32'd1 << (div + 1)) - 32'd1);
        for (int k = 0; k < n; k++) begin
            s_txd  = '0;
            s_busy = '0;
            s_irq  = '0;
            for (int c = 0; c <= div; c++) begin
                if (k != 0 || c != 0) step();
                s_txd[c]  = txd;
                s_busy[c] = Dout[2];
                s_irq[c]  = IRQ;
                if (mid_div >= 0 && k == 3 && c == 0) begin
                    Addr = A_DIV;
                    Din  = 32'(mid_div);
                    WE   = 1'b1;
                end
            end
            chk($sformatf("fr%02h_b%0d_txd", b, k), 32'(s_txd), bits[k] ? 32'(ones) : 32'h0);
            chk($sformatf("fr%02h_b%0d_busy", b, k), 32'(s_busy), 32'(ones));
            chk($sformatf("fr%02h_b%0d_irq", b, k), 32'(s_irq), 32'h0);
        end
        step();
        chk($sformatf("fr%02h_gap_txd", b), 32'(txd), 32'h1);
        chk($sformatf("fr%02h_gap_busy", b), 32'(Dout[2]), 32'h0);
        chk($sformatf("fr%02h_gap_irq", b), 32'(IRQ), 32'(irq_after));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0] par_tbl;
        n_vec = 0;
        n_bad = 0;
        reset = 1'b1;
        WE    = 1'b0;
        Addr  = A_STAT;
        Din   = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;

        // Reset state
        chk("rst_txd", 32'(txd), 32'h1);
        chk("rst_irq", 32'(IRQ), 32'h0);
        rd_chk("rst_ctrl", A_CTRL, 32'h0);
        rd_chk("rst_div", A_DIV, 32'd9);
        rd_chk("rst_data", A_DATA, 32'h0);
        rd_chk("rst_stat", A_STAT, 32'h2);

        // Single frame 0xA5, 4-cycle bits
        bus_wr(A_DIV, 32'd3);
        bus_wr(A_CTRL, 32'h1);
        bus_wr(A_DATA, 32'hA5);
        chk("a5_lat_txd", 32'(txd), 32'h1);
        chk("a5_lat_stat", Dout, 32'h10);
        step();
        expect_frame(8'hA5, 3, 1'b0, -1, 1'b0);

        // Overflow with EN=0, then drain with 1-cycle gaps
        bus_wr(A_CTRL, 32'h0);
        for (int i = 1; i <= 5; i++) bus_wr(A_DATA, 32'(i));
        rd_chk("ovf_stat", A_STAT, 32'h49);
        chk("ovf_irq", 32'(IRQ), 32'h0);
        bus_wr(A_STAT, 32'h8);
        rd_chk("ovf_clr_stat", A_STAT, 32'h41);
        bus_wr(A_CTRL, 32'h1);
        chk("drain_lat_txd", 32'(txd), 32'h1);
        par_tbl = 4'b1011;  // even parity of 0x01..0x04 -> 1,1,0,1 (bit i-1)
        for (int i = 1; i <= 4; i++) begin
            step();
            expect_frame(8'(i), 3, 1'b0, -1, par_tbl[i-1]);
        end
        rd_chk("drain_stat", A_STAT, 32'h2);

        // IRQ behaviour at DIVISOR=0
        bus_wr(A_CTRL, 32'h3);
        chk("irq_idle", 32'(IRQ), 32'h1);
        bus_wr(A_DIV, 32'd0);
        bus_wr(A_DATA, 32'h3C);
        chk("irq_drop1", 32'(IRQ), 32'h0);
        chk("irq_lat_txd", 32'(txd), 32'h1);
        step();
        expect_frame(8'h3C, 0, 1'b1, -1, 1'b0);
        bus_wr(A_DATA, 32'h55);
        chk("irq_drop2", 32'(IRQ), 32'h0);
        step();
        expect_frame(8'h55, 0, 1'b1, -1, 1'b0);

        // DIVISOR change mid-frame
        bus_wr(A_CTRL, 32'h0);
        bus_wr(A_DIV, 32'd3);
        bus_wr(A_DATA, 32'h96);
        bus_wr(A_DATA, 32'h0F);
        chk("div_q_stat", Dout, 32'h20);
        bus_wr(A_CTRL, 32'h1);
        chk("div_lat_txd", 32'(txd), 32'h1);
        step();
        expect_frame(8'h96, 3, 1'b0, 7, 1'b0);
        step();
        expect_frame(8'h0F, 7, 1'b0, -1, 1'b0);
        rd_chk("div_new", A_DIV, 32'd7);

        // Reset mid-frame
        bus_wr(A_DATA, 32'hAA);
        bus_wr(A_DATA, 32'h55);
        chk("mr_busy_stat", Dout, 32'h14);
        chk("mr_start_txd", 32'(txd), 32'h0);
        repeat (5) step();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mr_txd", 32'(txd), 32'h1);
        chk("mr_stat", Dout, 32'h2);
        chk("mr_irq", 32'(IRQ), 32'h0);
        rd_chk("mr_ctrl", A_CTRL, 32'h0);
        rd_chk("mr_div", A_DIV, 32'd9);
        repeat (3) step();
        chk("mr_quiet_txd", 32'(txd), 32'h1);

`ifdef UART_TX_PARITY_EN
        // Odd and even parity on 0x03
        bus_wr(A_CTRL, 32'h5);
        rd_chk("par_ctrl", A_CTRL, 32'h5);
        bus_wr(A_DIV, 32'd1);
        bus_wr(A_DATA, 32'h03);
        chk("par_odd_lat", 32'(txd), 32'h1);
        step();
        expect_frame(8'h03, 1, 1'b0, -1, 1'b1);
        bus_wr(A_CTRL, 32'h1);
        bus_wr(A_DATA, 32'h03);
        chk("par_even_lat", 32'(txd), 32'h1);
        step();
        expect_frame(8'h03, 1, 1'b0, -1, 1'b0);
`else
        // Without parity support CTRL bit 2 reads back 0
        bus_wr(A_CTRL, 32'h7);
        rd_chk("nopar_ctrl", A_CTRL, 32'h3);
        bus_wr(A_CTRL, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
